barrel_rotr_pipe: RTL and testbench

BARREL_ROTR_PIPE -- requirements
Module: barrel_rotr_pipe

---
 rtl/barrel_pkg.sv | 13 +
 rtl/barrel_rotr_pipe_if.sv | 28 ++
 rtl/shift_stage.sv | 61 ++++++
 rtl/barrel_rotr_pipe.sv | 62 ++++++
 tb/tb_barrel_rotr_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_pkg.sv
// Shared constants for the pipelined barrel shifter: shift-mode encodings and default width.
package barrel_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        MODE_LSR  = 2'b00,
        MODE_ASR  = 2'b01,
        MODE_ROR  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

endpackage

// File: rtl/barrel_rotr_pipe_if.sv
// Operand/result valid-ready bus of the pipelined barrel shifter.
interface barrel_rotr_pipe_if
    import barrel_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    localparam int S = $clog2(W);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [S-1:0] in_amt;
    mode_e        in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shifts right by 2^K and registers data/amt/mode/valid.
module shift_stage
    import barrel_pkg::*;
#(
    parameter int W = DEFAULT_W,
    parameter int S = $clog2(W),
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic [S-1:0] up_amt,
    input  mode_e        up_mode,
    input  logic         dn_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    output logic [S-1:0] dn_amt,
    output mode_e        dn_mode
);
    localparam int SH = 1 << K;

    logic         ld;
    logic         sign;
    logic [W-1:0] shifted;

    // Stage may load when empty or when its contents move on this edge.
    assign ld = !dn_valid || dn_ready;

    // ASR keeps the sign in the MSB at every stage, so the operand's current MSB is the original sign.
    assign sign = up_data[W-1];

    always_comb begin
        shifted = up_data;
        if (up_amt[K]) begin
            case (up_mode)
                MODE_LSR: shifted = {{SH{1'b0}}, up_data[W-1:SH]};
                MODE_ASR: shifted = {{SH{sign}}, up_data[W-1:SH]};
                MODE_ROR: shifted = {up_data[SH-1:0], up_data[W-1:SH]};
                default:  shifted = up_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amt   <= '0;
            dn_mode  <= MODE_LSR;
        end else if (ld) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= shifted;
                dn_amt  <= up_amt;
                dn_mode <= up_mode;
            end
        end
    end

endmodule

// File: rtl/barrel_rotr_pipe.sv
// Log2(W)-stage pipelined right shifter (logical/arithmetic/rotate/pass) with valid-ready flow control.
module barrel_rotr_pipe
    import barrel_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    barrel_rotr_pipe_if.slave  bus
);
    localparam int S = $clog2(W);

    // Index 0 is the input port; index k+1 is the output register of stage k.
    logic [S:0]        vld_pipe;
    logic [S:0]        rdy;
    logic [S:0][W-1:0] data;
    logic [S:0][S-1:0] amt;
    mode_e             mode [S:0];

    assign vld_pipe[0] = bus.in_valid;
    assign data[0]     = bus.in_data;
    assign amt[0]      = bus.in_amt;
    assign mode[0]     = bus.in_mode;

    // rdy[k] is the ready into stage k; it collapses bubbles back from the output.
    always_comb begin
        rdy    = '0;
        rdy[S] = bus.out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            rdy[k] = !vld_pipe[k+1] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        shift_stage #(
            .W (W),
            .S (S),
            .K (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld_pipe[k]),
            .up_data  (data[k]),
            .up_amt   (amt[k]),
            .up_mode  (mode[k]),
            .dn_ready (rdy[k+1]),
            .dn_valid (vld_pipe[k+1]),
            .dn_data  (data[k+1]),
            .dn_amt   (amt[k+1]),
            .dn_mode  (mode[k+1])
        );
    end

    // The retired amt/mode of the final stage have no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{amt[S], mode[S]};

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_pipe[S];
    assign bus.out_data  = data[S];

endmodule

// File: tb/tb_barrel_rotr_pipe.sv
// Directed and random self-checking bench for barrel_rotr_pipe at W=8.
module tb_barrel_rotr_pipe;
    import barrel_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrel_rotr_pipe_if #(.W(W)) bus();

    barrel_rotr_pipe #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Directed vectors: data, amt, mode, hand-computed result.
    logic [7:0] td [12] = '{8'h90, 8'h90, 8'h90, 8'h90, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h01, 8'h7F, 8'hB4};
    logic [2:0] ta [12] = '{3'd2, 3'd2, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd1, 3'd3, 3'd7};
    mode_e      tm [12] = '{MODE_ASR, MODE_LSR, MODE_ASR, MODE_LSR, MODE_LSR, MODE_ASR, MODE_ROR, MODE_PASS,
                            MODE_PASS, MODE_ROR, MODE_ASR, MODE_ROR};
    logic [7:0] te [12] = '{8'hE4, 8'h24, 8'hFF, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h80, 8'h0F, 8'h69};

    function automatic logic [7:0] ref_shift(logic [7:0] d, logic [2:0] a, mode_e m);
        logic signed [7:0] s;
        logic [15:0] dd;
        s  = d;
        dd = {d, d};
        case (m)
            MODE_LSR: return d >> a;
            MODE_ASR: return s >>> a;
            MODE_ROR: begin dd = dd >> a; return dd[7:0]; end
            default:  return d;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_amt   = '0;
        bus.in_mode  = MODE_LSR;
    endtask

    task automatic run_one(input logic [7:0] d, input logic [2:0] a, input mode_e m,
                           output logic [7:0] res, output bit ok);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        step;
        idle;
        ok  = 1'b0;
        res = '0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid) begin
                res = bus.out_data;
                ok  = 1'b1;
            end
            step;
        end
    endtask

    task automatic test_reset;
        idle;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step;
        step;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        step;
    endtask

    task automatic test_rotate;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hB4;
        bus.in_amt    = 3'd3;
        bus.in_mode   = MODE_ROR;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL rot_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        step;
        idle;
        for (int c = 1; c <= 2; c++) begin
            total_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL rot_early_valid_%0d: got %b want 0", c, bus.out_valid);
            else pass_cnt++;
            step;
        end
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL rot_latency_valid: got %b want 1", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 8'h96) $display("FAIL rot_data: got %h want 96", bus.out_data);
        else pass_cnt++;
        step;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rot_drained: got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_shift_modes;
        logic [7:0] res;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            run_one(td[i], ta[i], tm[i], res, ok);
            total_cnt++;
            if (!ok) $display("FAIL mode_vec_%0d: no result within bound, want %h", i, te[i]);
            else if (res !== te[i]) $display("FAIL mode_vec_%0d: got %h want %h", i, res, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sd [16];
        logic [2:0] sa [16];
        mode_e      sm [16];
        logic [7:0] outs [16];
        int got = 0, first = -1, last = -1;
        bit ready_ok = 1'b1;
        idle;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                sd[c] = 8'(c * 29 + 7);
                sa[c] = 3'(c);
                sm[c] = mode_e'(2'(c % 4));
                bus.in_valid = 1'b1;
                bus.in_data  = sd[c];
                bus.in_amt   = sa[c];
                bus.in_mode  = sm[c];
            end else begin
                idle;
            end
            #1;
            if (c < 16 && bus.in_ready !== 1'b1) ready_ok = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (got < 16) outs[got] = bus.out_data;
                if (first < 0) first = c;
                last = c;
                got++;
            end
            step;
        end
        total_cnt++;
        if (!ready_ok) $display("FAIL b2b_in_ready: got dropped want constant 1");
        else pass_cnt++;
        total_cnt++;
        if (got != 16) $display("FAIL b2b_count: got %0d want 16", got);
        else pass_cnt++;
        total_cnt++;
        if (last - first != 15) $display("FAIL b2b_consecutive: got span %0d want 15", last - first);
        else pass_cnt++;
        for (int i = 0; i < 16 && i < got; i++) begin
            total_cnt++;
            if (outs[i] !== ref_shift(sd[i], sa[i], sm[i]))
                $display("FAIL b2b_data_%0d: got %h want %h", i, outs[i], ref_shift(sd[i], sa[i], sm[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] bd [4] = '{8'h81, 8'h81, 8'h81, 8'h55};
        logic [2:0] ba [4] = '{3'd1, 3'd1, 3'd4, 3'd0};
        mode_e      bm [4] = '{MODE_ASR, MODE_LSR, MODE_ROR, MODE_PASS};
        logic [7:0] be [3] = '{8'hC0, 8'h40, 8'h18};
        int idx = 0, got = 0;
        idle;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bd[idx];
                bus.in_amt   = ba[idx];
                bus.in_mode  = bm[idx];
            end else begin
                idle;
            end
            #1;
            if (c >= 3) begin
                total_cnt++;
                if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b want 0", c, bus.in_ready);
                else pass_cnt++;
                total_cnt++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0)
                    $display("FAIL bp_hold_c%0d: got v=%b d=%h want v=1 d=c0", c, bus.out_valid, bus.out_data);
                else pass_cnt++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            step;
        end
        total_cnt++;
        if (idx != 3) $display("FAIL bp_accepted: got %0d want 3", idx);
        else pass_cnt++;
        idle;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid === 1'b1) begin
                if (got < 3) begin
                    total_cnt++;
                    if (bus.out_data !== be[got]) $display("FAIL bp_drain_%0d: got %h want %h", got, bus.out_data, be[got]);
                    else pass_cnt++;
                end
                got++;
            end
            step;
        end
        total_cnt++;
        if (got != 3) $display("FAIL bp_drain_count: got %0d want 3", got);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight;
        int stale = 0;
        idle;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h11 * (i + 1));
            bus.in_amt   = 3'd1;
            bus.in_mode  = MODE_LSR;
            step;
        end
        idle;
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL rst_mid_full: got %b want 1", bus.out_valid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", bus.out_data);
        else pass_cnt++;
        step;
        step;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready);
        else pass_cnt++;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid !== 1'b0) stale++;
            step;
        end
        total_cnt++;
        if (stale != 0) $display("FAIL rst_mid_stale: got %0d results want 0", stale);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [7:0] q [$];
        logic [7:0] exp;
        int sent = 0, rcvd = 0, cyc = 0;
        bit hold = 1'b0;
        idle;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            if (!hold) begin
                if (sent < 10000 && $urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 8'($urandom);
                    bus.in_amt   = 3'($urandom);
                    bus.in_mode  = mode_e'(2'($urandom));
                end else begin
                    idle;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_shift(bus.in_data, bus.in_amt, bus.in_mode));
                sent++;
                hold = 1'b0;
            end else begin
                hold = bus.in_valid;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL rand_extra_%0d: got %h want no result", rcvd, bus.out_data);
                end else begin
                    exp = q.pop_front();
                    if (bus.out_data !== exp) $display("FAIL rand_data_%0d: got %h want %h", rcvd, bus.out_data, exp);
                    else pass_cnt++;
                end
                rcvd++;
            end
            step;
            cyc++;
        end
        idle;
        total_cnt++;
        if (rcvd != 10000 || q.size() != 0)
            $display("FAIL rand_count: got %0d results (%0d pending) want 10000", rcvd, q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_rotate;
        test_shift_modes;
        test_back_to_back;
        test_backpressure;
        test_reset_midflight;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
